aes_round_ctrl: RTL and testbench

Round sequencer for the byte-serial AES-128 encryption datapath. It drives the per-phase start strobes and the shared 4-bit byte counter (count) into the SubBytes, ShiftRows, MixColumns and AddRoundKey stages, which share the state memory. It walks round 0 (AddRoundKey only), rounds 1..NUM_ROUNDS-1 (all four phases) and the final round (no MixColumns). Before every AddRoundKey phase it fetches the round key over a req/ack handshake with the key-expansion block.

---
 rtl/aes_round_ctrl.sv | 113 +++++++++++
 tb/tb_aes_round_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the byte-serial AES-128 datapath: steps the SubBytes, ShiftRows,
// MixColumns and AddRoundKey phases over a shared byte counter and fetches each round key.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  input  logic       key_ack,
  output logic       busy,
  output logic       key_req,
  output logic [3:0] key_round,
  output logic [3:0] round,
  output logic [3:0] count,
  output logic       SUB_BYTES_start,
  output logic       SHIFT_ROWS_start,
  output logic       MIX_COL_start,
  output logic       ADD_ROUND_start,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, KEY_WAIT, ADD, SUB, SHIFT, MIX, FIN} state_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_t     state_q, state_d;
  logic [3:0] count_d, round_d, key_round_d;
  logic       phase_act, adv, busy_d;

  // Strobes are the registered phase gated by the live stall, so a stalled
  // cycle never consumes a byte index.
  assign SUB_BYTES_start  = (state_q == SUB)   && !stall;
  assign SHIFT_ROWS_start = (state_q == SHIFT) && !stall;
  assign MIX_COL_start    = (state_q == MIX)   && !stall;
  assign ADD_ROUND_start  = (state_q == ADD)   && !stall;

  assign phase_act = SUB_BYTES_start | SHIFT_ROWS_start | MIX_COL_start | ADD_ROUND_start;
  assign adv       = phase_act && (count == 4'd15);

  always_comb begin
    state_d     = state_q;
    count_d     = count;
    round_d     = round;
    key_round_d = key_round;
    if (phase_act) count_d = count + 4'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = KEY_WAIT;
          round_d     = 4'd0;
          key_round_d = 4'd0;
        end
      end
      KEY_WAIT: begin
        count_d = 4'd0;
        if (key_ack) state_d = ADD;
      end
      SUB: if (adv) state_d = SHIFT;
      SHIFT: begin
        if (adv) begin
          if (round < LAST_RND) begin
            state_d = MIX;
          end else begin
            state_d     = KEY_WAIT;
            key_round_d = round;
          end
        end
      end
      MIX: begin
        if (adv) begin
          state_d     = KEY_WAIT;
          key_round_d = round;
        end
      end
      ADD: begin
        if (adv) begin
          if (round == LAST_RND) begin
            state_d = FIN;
          end else begin
            state_d = SUB;
            round_d = round + 4'd1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE) && (state_d != FIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count     <= 4'd0;
      round     <= 4'd0;
      key_round <= 4'd0;
      busy      <= 1'b0;
      key_req   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count     <= count_d;
      round     <= round_d;
      key_round <= key_round_d;
      busy      <= busy_d;
      key_req   <= (state_d == KEY_WAIT);
      done      <= (state_d == FIN);
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: nominal, key handshake, stall, start-while-busy,
// mid-run reset, and a NUM_ROUNDS=1 instance.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, start_b, stall, key_ack;
  logic       busy, key_req, done, sub_s, shift_s, mix_s, add_s;
  logic [3:0] key_round, round, count;
  logic       b_busy, b_key_req, b_done, b_sub, b_shift, b_mix, b_add;
  logic [3:0] b_key_round, b_round, b_count;
  logic [3:0] strb;
  logic [18:0] all_a, all_b;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .key_ack(key_ack),
    .busy(busy), .key_req(key_req), .key_round(key_round), .round(round), .count(count),
    .SUB_BYTES_start(sub_s), .SHIFT_ROWS_start(shift_s), .MIX_COL_start(mix_s),
    .ADD_ROUND_start(add_s), .done(done));

  aes_round_ctrl #(.NUM_ROUNDS(1)) dut_r1 (
    .clk(clk), .rst(rst), .start(start_b), .stall(stall), .key_ack(key_ack),
    .busy(b_busy), .key_req(b_key_req), .key_round(b_key_round), .round(b_round), .count(b_count),
    .SUB_BYTES_start(b_sub), .SHIFT_ROWS_start(b_shift), .MIX_COL_start(b_mix),
    .ADD_ROUND_start(b_add), .done(b_done));

  assign strb  = {add_s, mix_s, shift_s, sub_s};
  assign all_a = {busy, key_req, done, strb, count, round, key_round};
  assign all_b = {b_busy, b_key_req, b_done, b_add, b_mix, b_shift, b_sub, b_count, b_round, b_key_round};

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // trace statistics gathered at the falling edge
  bit         mon_en = 1'b0;
  int         busy_cyc, done_cyc, done_at, kreq_cyc, kr_n, kr_err;
  int         ord_err, seq_n, seq_err, hot_err, mix_fin;
  int         n_ph[4];
  int         bb_busy, bb_done;
  int         bb_ph[4];
  logic [3:0] exp_cnt;
  logic       kreq_q;
  int         exp_seq[64];
  int         exp_len;

  task automatic clear_stats();
    busy_cyc = 0; done_cyc = 0; done_at = -1; kreq_cyc = 0; kr_n = 0; kr_err = 0;
    ord_err = 0; seq_n = 0; seq_err = 0; hot_err = 0; mix_fin = 0;
    bb_busy = 0; bb_done = 0; exp_cnt = 4'd0; kreq_q = 1'b0;
    for (int i = 0; i < 4; i++) begin n_ph[i] = 0; bb_ph[i] = 0; end
  endtask

  task automatic sample();
    int ph;
    if (busy) busy_cyc++;
    if (done) begin
      if (done_cyc == 0) done_at = busy_cyc;
      done_cyc++;
    end
    if (key_req) kreq_cyc++;
    if (key_req && !kreq_q) begin
      if (int'(key_round) != kr_n) kr_err++;
      kr_n++;
    end
    kreq_q = key_req;
    if ($countones(strb) > 1) hot_err++;
    if (strb != 4'd0) begin
      ph = add_s ? 3 : mix_s ? 2 : shift_s ? 1 : 0;
      n_ph[ph]++;
      if (count != exp_cnt) ord_err++;
      exp_cnt = exp_cnt + 4'd1;
      if (count == 4'd0) begin
        if (seq_n >= exp_len || exp_seq[seq_n] != ph * 16 + int'(round)) seq_err++;
        seq_n++;
      end
      if (mix_s && round == 4'd10) mix_fin++;
    end
    if (b_busy) bb_busy++;
    if (b_done) bb_done++;
    if (b_sub)   bb_ph[0]++;
    if (b_shift) bb_ph[1]++;
    if (b_mix)   bb_ph[2]++;
    if (b_add)   bb_ph[3]++;
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) sample();
  end

  // mode: 0 nominal, 1 slow key_ack, 2 stall, 3 start while busy, 4 reset mid-run
  task automatic run(input int mode);
    int st, kw, post, hold_val, exp_busy;
    bit s1, s2, seen;
    clear_stats();
    st = 0; kw = 0; post = 0; hold_val = 0; s1 = 0; s2 = 0; seen = 0;
    exp_busy = (mode == 1) ? 706 : (mode == 2) ? 656 : 651;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start   = 1'b1;
    start_b = (mode == 0);
    key_ack = (mode != 1);
    @(posedge clk); #1;
    start   = 1'b0;
    start_b = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (mode == 1) begin
        if (key_req) begin kw++; key_ack = (kw > 5); end
        else begin kw = 0; key_ack = 1'b0; end
      end
      if (mode == 2) begin
        if (st > 0) begin
          st--;
          if (st == 0) stall = 1'b0;
        end else if (!s1 && shift_s && count == 4'd7) begin
          s1 = 1; stall = 1'b1; st = 3; hold_val = 7;
        end else if (!s2 && add_s && count == 4'd15) begin
          s2 = 1; stall = 1'b1; st = 2; hold_val = 15;
        end
        if (stall) begin
          #1;
          chk("stall_count", int'(count), hold_val);
          chk("stall_strobe", int'(strb), 0);
        end
      end
      if (mode == 3) start = (cyc == 100 || cyc == 300);
      if (mode == 4 && mix_s && round == 4'd4 && count == 4'd9) begin
        rst = 1'b0;
        #1;
        chk("midrst_outputs", int'(all_a), 0);
        seen = 1;
        break;
      end
      if (done) seen = 1;
      if (seen) begin
        post++;
        if (post > 3) break;
      end
      @(posedge clk); #1;
    end
    chk("finished_in_bound", int'(seen), 1);
    if (mode == 4) begin
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_held", int'(all_a), 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_idle_after", int'(busy), 0);
      chk("midrst_no_done", done_cyc, 0);
      mon_en = 1'b0;
    end else begin
      mon_en = 1'b0;
      chk("busy_cycles", busy_cyc, exp_busy);
      chk("done_pulses", done_cyc, 1);
      chk("done_cycle", done_at, exp_busy);
      chk("keyreq_cycles", kreq_cyc, (mode == 1) ? 66 : 11);
      chk("key_round_seq", kr_err, 0);
      chk("key_waits", kr_n, 11);
      chk("sub_bytes", n_ph[0], 160);
      chk("shift_rows", n_ph[1], 160);
      chk("mix_cols", n_ph[2], 144);
      chk("add_round", n_ph[3], 176);
      chk("byte_order", ord_err, 0);
      chk("phase_order", seq_err, 0);
      chk("phase_count", seq_n, exp_len);
      chk("onehot", hot_err, 0);
      chk("mix_final_round", mix_fin, 0);
      chk("round_hold", int'(round), 10);
      if (mode == 0) begin
        chk("r1_busy_cycles", bb_busy, 66);
        chk("r1_done_pulses", bb_done, 1);
        chk("r1_sub", bb_ph[0], 16);
        chk("r1_shift", bb_ph[1], 16);
        chk("r1_mix", bb_ph[2], 0);
        chk("r1_add", bb_ph[3], 32);
      end
    end
    stall   = 1'b0;
    key_ack = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_b = 1'b0; stall = 1'b0; key_ack = 1'b0;
    // expected phase entries, encoded phase*16+round (SUB=0 SHIFT=1 MIX=2 ADD=3)
    exp_len = 0;
    exp_seq[exp_len++] = 48;
    for (int r = 1; r < 10; r++) begin
      exp_seq[exp_len++] = r;
      exp_seq[exp_len++] = 16 + r;
      exp_seq[exp_len++] = 32 + r;
      exp_seq[exp_len++] = 48 + r;
    end
    exp_seq[exp_len++] = 10;
    exp_seq[exp_len++] = 26;
    exp_seq[exp_len++] = 58;

    #12;
    chk("reset_state", int'(all_a), 0);
    chk("reset_state_r1", int'(all_b), 0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_in_reset", int'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run(0);
    run(1);
    run(2);
    run(3);
    run(4);
    run(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
